// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and FSM state type for the CORDIC blocks.
package cordic_pkg;

    localparam int unsigned ATAN_LEN     = 14;
    localparam int          PI_2         = 25735;
    localparam int          CORDIC_K_Q14 = 26981;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } cordic_state_e;

    // atan(2^-i) in Q2.14, truncated.
    function automatic int atan_lut(input int unsigned i);
        int r;
        case (i)
            0:       r = 12867;
            1:       r = 7596;
            2:       r = 4013;
            3:       r = 2037;
            4:       r = 1022;
            5:       r = 511;
            6:       r = 255;
            7:       r = 127;
            8:       r = 63;
            9:       r = 31;
            10:      r = 15;
            11:      r = 7;
            12:      r = 3;
            13:      r = 1;
            default: r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational vectoring-mode micro-rotation: drives Y towards zero and
// accumulates the rotated angle in Z.
module cordic_vec_step #(
    parameter int unsigned XW = 18,
    parameter int unsigned ZW = 17,
    parameter int unsigned SW = 4
) (
    input  logic signed [XW-1:0] x_i,
    input  logic signed [XW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [SW-1:0] shift_i,
    input  logic signed [ZW-1:0] atan_i,
    output logic signed [XW-1:0] x_o,
    output logic signed [XW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    assign x_sh = x_i >>> shift_i;
    assign y_sh = y_i >>> shift_i;

    always_comb begin
        if (y_i[XW-1]) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atan_i;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atan_i;
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (x, y) -> uncompensated magnitude and atan2(y, x),
// one micro-rotation per clock between valid/ready handshakes.
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned STEPS = 14,
    parameter int unsigned GUARD = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [BITS-1:0]       x_in,
    input  logic signed [BITS-1:0]       y_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [BITS+GUARD-1:0] mag_out,
    output logic signed [BITS:0]         ang_out
);

    localparam int unsigned XW   = BITS + GUARD;
    localparam int unsigned ZW   = BITS + 1;
    localparam int unsigned CntW = (STEPS > 1) ? $clog2(STEPS + 1) : 1;

    cordic_state_e        state_q, state_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d, mag_q, mag_d;
    logic signed [ZW-1:0] z_q, z_d, ang_q, ang_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic signed [XW-1:0] x_ext, y_ext, x_pre, y_pre, x_nxt, y_nxt;
    logic signed [ZW-1:0] z_pre, z_nxt, atan_cur;

    assign x_ext    = XW'(x_in);
    assign y_ext    = XW'(y_in);
    assign atan_cur = ZW'(atan_lut(32'(cnt_q)));

    // Fold the left half-plane into the right one; y=0 with x<0 lands on +pi.
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = '0;
        if (x_in[BITS-1] && !y_in[BITS-1]) begin
            x_pre = y_ext;
            y_pre = -x_ext;
            z_pre = ZW'(PI_2);
        end else if (x_in[BITS-1] && y_in[BITS-1]) begin
            x_pre = -y_ext;
            y_pre = x_ext;
            z_pre = -ZW'(PI_2);
        end
    end

    cordic_vec_step #(
        .XW(XW),
        .ZW(ZW),
        .SW(CntW)
    ) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .shift_i(cnt_q),
        .atan_i (atan_cur),
        .x_o    (x_nxt),
        .y_o    (y_nxt),
        .z_o    (z_nxt)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        ang_d   = ang_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = x_pre;
                    y_d     = y_pre;
                    z_d     = z_pre;
                    cnt_d   = '0;
                    state_d = StIter;
                end
            end
            StIter: begin
                x_d   = x_nxt;
                y_d   = y_nxt;
                z_d   = z_nxt;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(STEPS - 1)) begin
                    mag_d   = x_nxt;
                    ang_d   = z_nxt;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            ang_q   <= ang_d;
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign mag_out   = mag_q;
    assign ang_out   = ang_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Directed bench for cordic_vector: quadrant cases, full-scale input, backpressure
// and a mid-iteration reset, against hand-computed magnitudes and angles.
module tb_cordic_vector;

    localparam int BITS  = 16;
    localparam int GUARD = 2;
    localparam int STEPS = 14;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         in_valid = 1'b0;
    logic                         out_ready = 1'b0;
    logic                         in_ready;
    logic                         out_valid;
    logic signed [BITS-1:0]       x_in = '0;
    logic signed [BITS-1:0]       y_in = '0;
    logic signed [BITS+GUARD-1:0] mag_out;
    logic signed [BITS:0]         ang_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cordic_vector #(
        .BITS (BITS),
        .STEPS(STEPS),
        .GUARD(GUARD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mag_out  (mag_out),
        .ang_out  (ang_out)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic signed [31:0] obs, input int exp,
                             input int tol);
        n_cmp++;
        assert (!$isunknown(obs) && (obs >= exp - tol) && (obs <= exp + tol)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Present one sample, wait for out_valid (bounded) and return the result.
    task automatic issue(input int x, input int y, output int mag, output int ang);
        int k;
        @(negedge clk);
        check_eq("in_ready before accept", 32'(in_ready), 1);
        in_valid = 1'b1;
        x_in     = BITS'(x);
        y_in     = BITS'(y);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (out_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("latency edges", k - 1, STEPS);
        mag = int'(mag_out);
        ang = int'(ang_out);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("out_valid after handshake", 32'(out_valid), 0);
        check_eq("in_ready after handshake", 32'(in_ready), 1);
    endtask

    initial begin
        int mag, ang, seen;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("in_ready in reset", 32'(in_ready), 0);
        check_eq("out_valid in reset", 32'(out_valid), 0);
        check_eq("mag in reset", mag_out, 0);
        check_eq("ang in reset", ang_out, 0);
        rst_n = 1'b1;
        #1;
        check_eq("in_ready after reset", 32'(in_ready), 1);

        // +x axis
        issue(16384, 0, mag, ang);
        check_tol("ang (1,0)", ang, 0, 8);
        check_tol("mag (1,0)", mag, 26981, 8);
        release_out();

        // +y axis, then hold in DONE under backpressure with a competing in_valid
        issue(0, 16384, mag, ang);
        check_tol("ang (0,1)", ang, 25736, 8);
        check_tol("mag (0,1)", mag, 26981, 8);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            x_in     = BITS'(-5000);
            y_in     = BITS'(7000);
            @(negedge clk);
            check_eq("bp out_valid held", 32'(out_valid), 1);
            check_eq("bp in_ready low", 32'(in_ready), 0);
            check_eq("bp mag stable", mag_out, mag);
            check_eq("bp ang stable", ang_out, ang);
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1;
        end
        check_eq("busy in_valid not accepted", seen, 0);

        // -x axis must land on +pi
        issue(-16384, 0, mag, ang);
        check_tol("ang (-1,0)", ang, 51472, 8);
        check_eq("ang (-1,0) positive", 32'(ang > 0), 1);
        check_tol("mag (-1,0)", mag, 26981, 8);
        release_out();

        // Full-scale third quadrant
        issue(-32768, -32768, mag, ang);
        check_tol("ang (-2,-2)", ang, -38604, 8);
        check_tol("mag (-2,-2)", mag, 76314, 16);
        release_out();

        // Reset during iteration 5 discards the sample
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = BITS'(8000);
        y_in     = BITS'(-3000);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid-reset in_ready", 32'(in_ready), 0);
        check_eq("mid-reset out_valid", 32'(out_valid), 0);
        check_eq("mid-reset mag", mag_out, 0);
        check_eq("mid-reset ang", ang_out, 0);
        rst_n = 1'b1;
        #1;
        check_eq("post-reset in_ready", 32'(in_ready), 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1;
        end
        check_eq("aborted sample never valid", seen, 0);

        issue(16384, 16384, mag, ang);
        check_tol("ang (1,1)", ang, 12868, 8);
        check_tol("mag (1,1)", mag, 38157, 8);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
